io_output_bank: RTL and testbench
=================================

# io_output_bank

Parametrised memory-mapped output port bank on the CPU I/O bus. It provides NPORTS registered output ports with plain, set, clear and toggle write modes, and registered readback. It also has an optional per-port auto-clear pulse mode driven by down-counters. It sits beside data memory and decodes the same word-address field, addr[7:2].

## Interface
- NPORTS, 4: number of output ports, 1..8.
- DATA_W, 32: port width, 1..32.
- BASE_IDX, 32: word index (addr[7:2]) of port 0. Port i is at BASE_IDX+i.
- CTRL_IDX, 40: word index of the pulse-enable mask. CTRL_IDX+1 is the pulse-length register.
- PULSE_W, 16: pulse counter width.
- io_clk  in  1  clock; all state updates on the rising edge.
- clrn  in  1  asynchronous active-low reset.
- addr  in  32  bus address. Uses [7:2] as word index and [9:8] as write mode. Other bits are ignored.
- datain  in  DATA_W  write data.
- write_io_enable  in  1  write strobe, sampled at the rising edge.
- read_io_enable  in  1  read strobe, sampled at the rising edge.
- dataout  out  DATA_W  registered read data.
- out_port  out  NPORTS*DATA_W  flattened ports. Port i is at bits [i*DATA_W +: DATA_W].
- pulse_active  out  NPORTS  bit i high while the pulse counter of port i is nonzero.

## Operation
- Reset (clrn=0, asynchronous) clears all of the following to 0 and holds them while low:
  - every port;
  - the mask register (NPORTS bits);
  - the pulse-length register (PULSE_W bits);
  - all counters;
  - dataout.
- Port write: write_io_enable=1 with word index BASE_IDX+i, i<NPORTS. addr[9:8] selects the new value:
  - 00: port = datain;
  - 01: port = port | datain;
  - 10: port = port & ~datain;
  - 11: port = port ^ datain.
- Control writes ignore addr[9:8]:
  - CTRL_IDX: mask = datain[NPORTS-1:0];
  - CTRL_IDX+1: pulse length = datain[PULSE_W-1:0].
- Writes to unmapped indices have no effect.
- Pulse mode, per port i:
  - A port-i write with mask[i]=1 and pulse length L≠0 loads counter[i]=L. The write uses the length value before any same-edge length write.
  - While counter[i]>1 it decrements by 1 each edge.
  - At the edge where counter[i]==1: port i is cleared to 0 and counter[i] becomes 0.
  - The written value is therefore visible for exactly L cycles.
  - With L=0 or mask[i]=0, a write loads nothing and the value is held indefinitely.
- Pulse boundary cases:
  - A rewrite while the counter is active reloads it to L, even if the counter would have expired on that edge. The write wins and the port takes the write result.
  - A mask write clearing bit i zeroes counter[i] at that edge. Port i keeps its value.
  - A mask write setting bit i does not start a counter by itself.
  - A pulse-length change does not affect running counters.
- Read: read_io_enable=1 loads dataout at the edge with:
  - port i value, for a port index;
  - mask, zero-extended, for CTRL_IDX;
  - pulse length, zero-extended, for CTRL_IDX+1;
  - 0 for any other index.
- When read_io_enable=0, dataout holds its value.
- Simultaneous read and write of the same register at one edge: dataout gets the pre-write value.
- Unused counter upper bits: none. Counters are exactly PULSE_W bits.

## Timing
- Write latency: out_port updates at the same rising edge that samples write_io_enable=1.
- Read latency: dataout is valid after the sampling edge and stays stable until the next read.
- pulse_active[i] is combinational from counter[i]. It rises after the loading edge and falls after the expiry edge.
- No handshake, no stalls. One access of each kind may occur every cycle.
- Reset assertion mid-pulse clears the port and counter immediately. After deassertion the block is idle with all outputs 0.

## Test plan
- Reset, then write 0xA5A5A5A5 mode 00 to port 2 (addr 0x88) -> out_port port 2 = 0xA5A5A5A5 after that edge, other ports 0. Read 0x88 -> dataout = 0xA5A5A5A5 next cycle.
- Port 0 = 0x0F0F0000, then:
  - set 0x000000FF (addr 0x180) -> 0x0F0F00FF;
  - clear 0x0F000000 (addr 0x280) -> 0x000F00FF;
  - toggle 0xFFFFFFFF (addr 0x380) -> 0xFFF0FF00.
- Mask=0b0010, length=3, write 0x55 to port 1 -> port 1 = 0x55 for exactly 3 cycles, then 0. pulse_active[1] is high for those 3 cycles. Port 0 write of 0x55 holds indefinitely.
- Pulse reload: a rewrite of port 1 with 0x66 on the expiry edge -> port 1 = 0x66 for 3 further cycles. Clearing the mask mid-pulse -> value held, pulse_active[1] = 0.
- Same-edge write 0x77 and read of port 3 (prior value 0x11) -> dataout = 0x11, port 3 = 0x77.
- clrn pulled low mid-pulse -> all ports, mask, length, counters and dataout read 0 immediately. Reads of unmapped index 50 return 0.

Source files
------------

// File: rtl/io_output_bank.sv
// Memory-mapped output port bank: NPORTS registered ports with write/set/clear/toggle
// modes, registered readback and optional per-port auto-clear pulses.
module io_output_bank #(
    parameter int NPORTS   = 4,
    parameter int DATA_W   = 32,
    parameter int BASE_IDX = 32,
    parameter int CTRL_IDX = 40,
    parameter int PULSE_W  = 16
) (
    input  logic                     io_clk,
    input  logic                     clrn,
    input  logic [31:0]              addr,
    input  logic [DATA_W-1:0]        datain,
    input  logic                     write_io_enable,
    input  logic                     read_io_enable,
    output logic [DATA_W-1:0]        dataout,
    output logic [NPORTS*DATA_W-1:0] out_port,
    output logic [NPORTS-1:0]        pulse_active
);

    localparam logic [5:0]         MASK_IDX = 6'(CTRL_IDX);
    localparam logic [5:0]         LEN_IDX  = 6'(CTRL_IDX + 1);
    localparam logic [PULSE_W-1:0] CNT_ONE  = PULSE_W'(1);

    logic [5:0]         idx;
    logic [1:0]         mode;
    logic [DATA_W-1:0]  port_q [NPORTS];
    logic [PULSE_W-1:0] cnt_q  [NPORTS];
    logic [NPORTS-1:0]  mask_q;
    logic [PULSE_W-1:0] plen_q;
    logic [NPORTS-1:0]  port_hit;
    logic [NPORTS-1:0]  new_mask;
    logic               wr_mask;
    logic               wr_len;
    logic [DATA_W-1:0]  rd_data;
    logic               unused_addr;

    assign idx         = addr[7:2];
    assign mode        = addr[9:8];
    assign unused_addr = ^{addr[31:10], addr[1:0]};
    assign wr_mask     = write_io_enable && (idx == MASK_IDX);
    assign wr_len      = write_io_enable && (idx == LEN_IDX);
    assign new_mask    = NPORTS'(datain);

    function automatic logic [5:0] port_idx(input int i);
        return 6'(BASE_IDX + i);
    endfunction

    function automatic logic [DATA_W-1:0] apply_mode(input logic [1:0]        m,
                                                     input logic [DATA_W-1:0] cur,
                                                     input logic [DATA_W-1:0] wdat);
        case (m)
            2'b00:   return wdat;
            2'b01:   return cur | wdat;
            2'b10:   return cur & ~wdat;
            default: return cur ^ wdat;
        endcase
    endfunction

    always_comb begin
        port_hit = '0;
        rd_data  = '0;
        for (int i = 0; i < NPORTS; i++) begin
            port_hit[i] = write_io_enable && (idx == port_idx(i));
            if (idx == port_idx(i)) rd_data = port_q[i];
        end
        if (idx == MASK_IDX) rd_data = DATA_W'(mask_q);
        if (idx == LEN_IDX)  rd_data = DATA_W'(plen_q);
    end

    // A port write always beats expiry; counter loads use the pre-edge mask and length.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NPORTS; i++) begin
                port_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            mask_q  <= '0;
            plen_q  <= '0;
            dataout <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (port_hit[i])
                    port_q[i] <= apply_mode(mode, port_q[i], datain);
                else if (cnt_q[i] == CNT_ONE)
                    port_q[i] <= '0;

                if (wr_mask && !new_mask[i])
                    cnt_q[i] <= '0;
                else if (port_hit[i] && mask_q[i] && (plen_q != '0))
                    cnt_q[i] <= plen_q;
                else if (cnt_q[i] != '0)
                    cnt_q[i] <= cnt_q[i] - CNT_ONE;
            end
            if (wr_mask)        mask_q  <= new_mask;
            if (wr_len)         plen_q  <= PULSE_W'(datain);
            if (read_io_enable) dataout <= rd_data;
        end
    end

    for (genvar g = 0; g < NPORTS; g++) begin : g_out
        assign out_port[g*DATA_W +: DATA_W] = port_q[g];
        assign pulse_active[g]              = (cnt_q[g] != '0);
    end

endmodule

// File: tb/tb_io_output_bank.sv
// Directed bench for io_output_bank: write modes, readback, pulse timing, reload, reset.
module tb_io_output_bank;

    logic         io_clk = 1'b0;
    logic         clrn;
    logic [31:0]  addr;
    logic [31:0]  datain;
    logic         write_io_enable;
    logic         read_io_enable;
    logic [31:0]  dataout;
    logic [127:0] out_port;
    logic [3:0]   pulse_active;

    int checks   = 0;
    int failures = 0;

    io_output_bank dut (
        .io_clk         (io_clk),
        .clrn           (clrn),
        .addr           (addr),
        .datain         (datain),
        .write_io_enable(write_io_enable),
        .read_io_enable (read_io_enable),
        .dataout        (dataout),
        .out_port       (out_port),
        .pulse_active   (pulse_active)
    );

    always #5 io_clk = ~io_clk;

    task automatic step();
        @(posedge io_clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; datain = d; write_io_enable = 1'b1;
        step();
        write_io_enable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        addr = a; read_io_enable = 1'b1;
        step();
        read_io_enable = 1'b0;
    endtask

    task automatic test_reset();
        clrn = 1'b0; addr = '0; datain = '0;
        write_io_enable = 1'b0; read_io_enable = 1'b0;
        #12;
        checks++;
        if (out_port !== 128'h0) begin failures++; $display("FAIL reset_ports got=%h exp=0", out_port); end
        checks++;
        if (dataout !== 32'h0) begin failures++; $display("FAIL reset_dataout got=%h exp=0", dataout); end
        checks++;
        if (pulse_active !== 4'h0) begin failures++; $display("FAIL reset_active got=%b exp=0000", pulse_active); end
        clrn = 1'b1;
        step();
    endtask

    task automatic test_basic_write();
        wr(32'h88, 32'hA5A5_A5A5);
        checks++;
        if (out_port[64 +: 32] !== 32'hA5A5_A5A5) begin
            failures++; $display("FAIL p2_write got=%h exp=a5a5a5a5", out_port[64 +: 32]);
        end
        checks++;
        if (out_port !== {32'h0, 32'hA5A5_A5A5, 64'h0}) begin
            failures++; $display("FAIL other_ports got=%h exp=only port2 set", out_port);
        end
        rd(32'h88);
        checks++;
        if (dataout !== 32'hA5A5_A5A5) begin failures++; $display("FAIL p2_read got=%h exp=a5a5a5a5", dataout); end
    endtask

    task automatic test_modes();
        wr(32'h080, 32'h0F0F_0000);
        checks++;
        if (out_port[0 +: 32] !== 32'h0F0F_0000) begin failures++; $display("FAIL mode_write got=%h exp=0f0f0000", out_port[0 +: 32]); end
        wr(32'h180, 32'h0000_00FF);
        checks++;
        if (out_port[0 +: 32] !== 32'h0F0F_00FF) begin failures++; $display("FAIL mode_set got=%h exp=0f0f00ff", out_port[0 +: 32]); end
        wr(32'h280, 32'h0F00_0000);
        checks++;
        if (out_port[0 +: 32] !== 32'h000F_00FF) begin failures++; $display("FAIL mode_clear got=%h exp=000f00ff", out_port[0 +: 32]); end
        wr(32'h380, 32'hFFFF_FFFF);
        checks++;
        if (out_port[0 +: 32] !== 32'hFFF0_FF00) begin failures++; $display("FAIL mode_toggle got=%h exp=fff0ff00", out_port[0 +: 32]); end
    endtask

    task automatic test_pulse();
        wr(32'hA0, 32'h2);
        wr(32'hA4, 32'h3);
        rd(32'hA0);
        checks++;
        if (dataout !== 32'h2) begin failures++; $display("FAIL mask_read got=%h exp=2", dataout); end
        rd(32'hA4);
        checks++;
        if (dataout !== 32'h3) begin failures++; $display("FAIL len_read got=%h exp=3", dataout); end
        wr(32'h84, 32'h55);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_port[32 +: 32] !== 32'h55 || pulse_active !== 4'b0010) begin
                failures++;
                $display("FAIL pulse_hold c=%0d got=%h act=%b exp=55 act=0010", c, out_port[32 +: 32], pulse_active);
            end
            if (c < 2) step();
        end
        step();
        checks++;
        if (out_port[32 +: 32] !== 32'h0 || pulse_active !== 4'b0000) begin
            failures++; $display("FAIL pulse_expire got=%h act=%b exp=0 act=0000", out_port[32 +: 32], pulse_active);
        end
        wr(32'h80, 32'h55);
        repeat (5) step();
        checks++;
        if (out_port[0 +: 32] !== 32'h55 || pulse_active[0] !== 1'b0) begin
            failures++; $display("FAIL unmasked_hold got=%h act=%b exp=55 act=0", out_port[0 +: 32], pulse_active[0]);
        end
    endtask

    task automatic test_reload();
        wr(32'h84, 32'h55);
        step();
        step();
        checks++;
        if (out_port[32 +: 32] !== 32'h55 || pulse_active[1] !== 1'b1) begin
            failures++; $display("FAIL pre_expiry got=%h act=%b exp=55 act=1", out_port[32 +: 32], pulse_active[1]);
        end
        wr(32'h84, 32'h66);
        checks++;
        if (out_port[32 +: 32] !== 32'h66 || pulse_active[1] !== 1'b1) begin
            failures++; $display("FAIL reload_write got=%h act=%b exp=66 act=1", out_port[32 +: 32], pulse_active[1]);
        end
        step();
        step();
        checks++;
        if (out_port[32 +: 32] !== 32'h66) begin failures++; $display("FAIL reload_hold got=%h exp=66", out_port[32 +: 32]); end
        step();
        checks++;
        if (out_port[32 +: 32] !== 32'h0 || pulse_active[1] !== 1'b0) begin
            failures++; $display("FAIL reload_expire got=%h act=%b exp=0 act=0", out_port[32 +: 32], pulse_active[1]);
        end
        wr(32'h84, 32'h99);
        step();
        wr(32'hA0, 32'h0);
        checks++;
        if (out_port[32 +: 32] !== 32'h99 || pulse_active[1] !== 1'b0) begin
            failures++; $display("FAIL mask_clear got=%h act=%b exp=99 act=0", out_port[32 +: 32], pulse_active[1]);
        end
        repeat (4) step();
        checks++;
        if (out_port[32 +: 32] !== 32'h99) begin failures++; $display("FAIL mask_clear_hold got=%h exp=99", out_port[32 +: 32]); end
    endtask

    task automatic test_same_edge_rw();
        wr(32'h8C, 32'h11);
        addr = 32'h8C; datain = 32'h77;
        write_io_enable = 1'b1; read_io_enable = 1'b1;
        step();
        write_io_enable = 1'b0; read_io_enable = 1'b0;
        checks++;
        if (dataout !== 32'h11) begin failures++; $display("FAIL rw_dataout got=%h exp=11", dataout); end
        checks++;
        if (out_port[96 +: 32] !== 32'h77) begin failures++; $display("FAIL rw_port got=%h exp=77", out_port[96 +: 32]); end
    endtask

    task automatic test_async_reset();
        wr(32'hA0, 32'h2);
        wr(32'h84, 32'hAA);
        rd(32'h84);
        checks++;
        if (dataout !== 32'hAA || pulse_active[1] !== 1'b1) begin
            failures++; $display("FAIL pre_reset got=%h act=%b exp=aa act=1", dataout, pulse_active[1]);
        end
        #2 clrn = 1'b0;
        #1;
        checks++;
        if (out_port !== 128'h0 || pulse_active !== 4'h0 || dataout !== 32'h0) begin
            failures++; $display("FAIL async_reset ports=%h act=%b dout=%h exp=all 0", out_port, pulse_active, dataout);
        end
        #3 clrn = 1'b1;
        step();
        checks++;
        if (out_port !== 128'h0 || pulse_active !== 4'h0) begin
            failures++; $display("FAIL post_reset ports=%h act=%b exp=all 0", out_port, pulse_active);
        end
        wr(32'h80, 32'h1234);
        rd(32'hA0);
        checks++;
        if (dataout !== 32'h0) begin failures++; $display("FAIL mask_after_reset got=%h exp=0", dataout); end
        rd(32'hA4);
        checks++;
        if (dataout !== 32'h0) begin failures++; $display("FAIL len_after_reset got=%h exp=0", dataout); end
        checks++;
        if (out_port[0 +: 32] !== 32'h1234 || pulse_active[0] !== 1'b0) begin
            failures++; $display("FAIL no_pulse_after_reset got=%h act=%b exp=1234 act=0", out_port[0 +: 32], pulse_active[0]);
        end
    endtask

    task automatic test_unmapped();
        rd(32'h80);
        checks++;
        if (dataout !== 32'h1234) begin failures++; $display("FAIL p0_read got=%h exp=1234", dataout); end
        wr(32'hC8, 32'hDEAD_BEEF);
        checks++;
        if (out_port !== 128'h1234) begin failures++; $display("FAIL unmapped_write got=%h exp=1234", out_port); end
        rd(32'hC8);
        checks++;
        if (dataout !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", dataout); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_modes();
        test_pulse();
        test_reload();
        test_same_edge_rw();
        test_async_reset();
        test_unmapped();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
